// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Reads back a multiplexed 7-segment display bus (anode strobes plus segment
// lines) and recovers the BCD value shown on each digit slot. A slot is only
// captured once the bus has held one value for STABLE_CYCLES unchanged
// synchronised samples with exactly one anode asserted. Each slot carries a
// valid flag (cleared by a stale timeout), an illegal-pattern flag and its
// decoded nibble.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   an           anode strobes, bit i selects digit slot i
//   seg          segment lines, bit0=a .. bit6=g, bit7=dp
//   number_out   decoded BCD, slot i in bits [4i+3:4i] (4'hF after a bad code)
//   digit_valid  slot holds a legal capture that has not gone stale
//   code_err     last capture of the slot was an illegal pattern
//   update       one-cycle pulse on every capture
//   update_idx   slot written by the current update (0 when no update)
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              seg,
  output logic [4*NUM_DIGITS-1:0] number_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   code_err,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Raw pin level of a bus with no anode selected and no segment driven.
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURED
  } state_t;

  // Returns {legal, value}; anything outside the ten digit glyphs, or any
  // pattern with the decimal point lit, is illegal and reads as 4'hF.
  function automatic logic [4:0] decode_seg(input logic [7:0] s);
    logic [4:0] r;
    case (s[6:0])
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7D:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h67:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'hF};
    endcase
    if (s[7]) begin
      r = {1'b0, 4'hF};
    end
    return r;
  endfunction

  // Position of the set bit; only meaningful when the input is one-hot.
  function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  logic [NUM_DIGITS-1:0] an_p0, an_p1, an_p2;
  logic [7:0]            seg_p0, seg_p1, seg_p2;

  logic [NUM_DIGITS-1:0] a_act;
  logic [7:0]            s_act;
  logic                  changed;
  logic                  a_onehot;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  capture;
  logic [IDX_W-1:0]      cap_idx;
  logic [4:0]            cap_code;

  logic [TMO_W-1:0]      tmo_cnt [NUM_DIGITS];

  // ---- stage p0/p1: two-flop synchronisers; p2: previous settled sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p0  <= AN_IDLE;
      an_p1  <= AN_IDLE;
      an_p2  <= AN_IDLE;
      seg_p0 <= '0;
      seg_p1 <= '0;
      seg_p2 <= '0;
    end else begin
      an_p0  <= an;
      an_p1  <= an_p0;
      an_p2  <= an_p1;
      seg_p0 <= seg;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
    end
  end

  // Change detection works on raw levels; polarity only matters for decode.
  assign a_act    = an_p1 ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
  assign s_act    = seg_p1 ^ {8{SEG_ACTIVE_LOW}};
  assign changed  = (an_p1 != an_p2) || (seg_p1 != seg_p2);
  assign a_onehot = (a_act != '0) && ((a_act & (a_act - NUM_DIGITS'(1))) == '0);

  assign cap_idx  = onehot_index(a_act);
  assign cap_code = decode_seg(s_act);

  // ---- settle FSM: decides the capture cycle from the p1/p2 samples ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (changed) begin
      // Any change restarts the dwell; a new one-hot slot starts counting
      // from 1 so a mid-settle anode switch never yields a partial capture.
      if (a_onehot) begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = CNT_W'(1);
      end else begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt == CNT_W'(STABLE_CYCLES)) begin
            capture   = 1'b1;
            state_nxt = ST_CAPTURED;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_CAPTURED: state_nxt = ST_CAPTURED;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- output stage: per-slot capture registers and stale timeout ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_out  <= '0;
      digit_valid <= '0;
      code_err    <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        tmo_cnt[i] <= '0;
      end
    end else begin
      update     <= capture;
      update_idx <= capture ? cap_idx : '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        // A capture into this slot takes priority over its timeout.
        if (capture && (cap_idx == IDX_W'(i))) begin
          number_out[4*i +: 4] <= cap_code[3:0];
          digit_valid[i]       <= cap_code[4];
          code_err[i]          <= ~cap_code[4];
          tmo_cnt[i]           <= '0;
        end else begin
          if (tmo_cnt[i] != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt[i] <= tmo_cnt[i] + TMO_W'(1);
          end
          // Valid drops on the same edge the counter reaches the limit;
          // the nibble and error flag keep the last capture.
          if (tmo_cnt[i] >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
            digit_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
`timescale 1ns/1ps
module tb_seg7_scan_decoder;

  localparam int ND  = 4;
  localparam int STB = 4;
  localparam int TMO = 100;
  localparam int W   = STB + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [7:0]  seg = 8'h00;
  logic [15:0] number_out;
  logic [3:0]  digit_valid;
  logic [3:0]  code_err;
  logic        update;
  logic [1:0]  update_idx;

  seg7_scan_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(STB),
    .TIMEOUT_CYCLES(TMO),
    .AN_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .an(an),
    .seg(seg),
    .number_out(number_out),
    .digit_valid(digit_valid),
    .code_err(code_err),
    .update(update),
    .update_idx(update_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The bus value sampled at each clock edge is kept in a sliding window.
  // A dwell is a run of identical samples; a one-hot dwell that lasts for
  // STB unchanged samples after its first one is reported STB+2 edges after
  // the edge that first sampled it, once per dwell.
  logic [6:0]  pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
  logic [11:0] win [W];
  int          cyc;
  logic [3:0]  m_num  [ND];
  bit          m_ok   [ND];
  bit          m_have [ND];
  int          m_at   [ND];
  bit          m_upd;
  int          m_idx;
  logic [11:0] m_head;
  logic [3:0]  m_sel;
  bit          m_held;
  int          m_slot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < W; j++) win[j] = {4'hF, 8'h00};
      cyc   = 0;
      m_upd = 0;
      m_idx = 0;
      for (int i = 0; i < ND; i++) begin
        m_num[i] = 4'h0; m_ok[i] = 0; m_have[i] = 0; m_at[i] = 0;
      end
    end else begin
      cyc++;
      for (int j = W - 1; j > 0; j--) win[j] = win[j-1];
      win[0] = {an, seg};
      m_upd  = 0;
      m_head = win[STB+2];
      m_sel  = ~m_head[11:8];
      m_held = 1;
      for (int j = 2; j <= STB + 1; j++) if (win[j] != m_head) m_held = 0;
      if ((win[STB+3] != m_head) && m_held && ($countones(m_sel) == 1)) begin
        m_slot = 0;
        for (int i = 0; i < ND; i++) if (m_sel[i]) m_slot = i;
        m_num[m_slot] = 4'hF;
        m_ok[m_slot]  = 0;
        if (!m_head[7]) begin
          for (int d = 0; d < 10; d++) begin
            if (pat[d] == m_head[6:0]) begin
              m_num[m_slot] = 4'(d);
              m_ok[m_slot]  = 1;
            end
          end
        end
        m_have[m_slot] = 1;
        m_at[m_slot]   = cyc;
        m_upd = 1;
        m_idx = m_slot;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic [15:0] en;
    logic [3:0]  ev;
    logic [3:0]  ee;
    for (int i = 0; i < ND; i++) begin
      en[4*i +: 4] = m_num[i];
      ev[i] = m_have[i] && m_ok[i] && ((cyc - m_at[i]) < TMO);
      ee[i] = m_have[i] && !m_ok[i];
    end
    chk("number_out", 32'(number_out), 32'(en));
    chk("digit_valid", 32'(digit_valid), 32'(ev));
    chk("code_err", 32'(code_err), 32'(ee));
    chk("update", 32'(update), 32'(m_upd));
    if (m_upd) chk("update_idx", 32'(update_idx), 32'(m_idx));
  end

  // Update pulse log for the directed checks.
  int         n_upd = 0;
  logic [1:0] idxq [$];
  always @(negedge clk) begin
    if (update) begin
      n_upd++;
      idxq.push_back(update_idx);
    end
  end

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int base;
  int qb;
  int lat;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_number", 32'(number_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_err", 32'(code_err), 32'h0);
    chk("rst_update", 32'(update), 32'h0);
    chk("rst_idx", 32'(update_idx), 32'h0);

    // Idle bus.
    base = n_upd;
    hold(4'hF, 8'h00, 50);
    chk("idle_updates", 32'(n_upd - base), 32'd0);
    chk("idle_number", 32'(number_out), 32'h0);

    // Single digit on slot 0, latency measured from the first sampling edge.
    base = n_upd;
    an = 4'b1110; seg = 8'h5B;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (update) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(STB + 2));
    repeat (12) @(negedge clk);
    chk("single_updates", 32'(n_upd - base), 32'd1);
    chk("single_nibble", 32'(number_out[3:0]), 32'h2);
    chk("single_valid", 32'(digit_valid), 32'b0001);
    if (idxq.size() > 0) chk("single_idx", 32'(idxq[idxq.size()-1]), 32'd0);

    // Four-digit scan.
    base = n_upd;
    qb   = idxq.size();
    hold(4'b1110, 8'h06, 10);
    hold(4'b1101, 8'h5B, 10);
    hold(4'b1011, 8'h4F, 10);
    hold(4'b0111, 8'h66, 10);
    chk("scan_updates", 32'(n_upd - base), 32'd4);
    chk("scan_number", 32'(number_out), 32'h4321);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_err", 32'(code_err), 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (idxq.size() > qb + k) chk("scan_idx", 32'(idxq[qb+k]), 32'(k));
      else chk("scan_idx_missing", 32'(idxq.size()), 32'(qb + k + 1));
    end

    // Short glitch on slot 1 must not be captured.
    base = n_upd;
    hold(4'b1101, 8'h5B, 10);
    hold(4'b1101, 8'h4F, 2);
    hold(4'b1101, 8'h5B, 12);
    chk("glitch_updates", 32'(n_upd - base), 32'd2);
    chk("glitch_nibble", 32'(number_out[7:4]), 32'h2);

    // Two anodes at once: no capture.
    base = n_upd;
    hold(4'b1100, 8'h5B, 20);
    chk("contention_updates", 32'(n_upd - base), 32'd0);

    // Illegal codes on slot 2.
    hold(4'b1011, 8'h49, 12);
    chk("bad49_nibble", 32'(number_out[11:8]), 32'hF);
    chk("bad49_err", 32'(code_err[2]), 32'd1);
    chk("bad49_valid", 32'(digit_valid[2]), 32'd0);
    base = n_upd;
    hold(4'b1011, 8'h86, 12);
    chk("dp_updates", 32'(n_upd - base), 32'd1);
    chk("dp_err", 32'(code_err[2]), 32'd1);
    chk("dp_nibble", 32'(number_out[11:8]), 32'hF);
    hold(4'b1011, 8'h07, 12);
    chk("good7_nibble", 32'(number_out[11:8]), 32'h7);
    chk("good7_err", 32'(code_err[2]), 32'd0);
    chk("good7_valid", 32'(digit_valid[2]), 32'd1);

    // Timeout on slot 3.
    an = 4'b0111; seg = 8'h7D;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (update) begin
        lat = k;
        break;
      end
    end
    chk("tmo_capture_seen", 32'(lat > 0), 32'd1);
    chk("tmo_capture_valid", 32'(digit_valid[3]), 32'd1);
    an = 4'hF; seg = 8'h00;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!digit_valid[3]) begin
        lat = k;
        break;
      end
    end
    chk("tmo_delay", 32'(lat), 32'(TMO));
    chk("tmo_nibble_held", 32'(number_out[15:12]), 32'h6);
    chk("tmo_err_held", 32'(code_err[3]), 32'd0);

    // Reset in the middle of a settle.
    @(negedge clk);
    an = 4'b1110; seg = 8'h7F;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    an = 4'hF; seg = 8'h00;
    #1;
    chk("arst_number", 32'(number_out), 32'h0);
    chk("arst_valid", 32'(digit_valid), 32'h0);
    chk("arst_err", 32'(code_err), 32'h0);
    chk("arst_update", 32'(update), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = n_upd;
    repeat (20) @(negedge clk);
    chk("post_rst_updates", 32'(n_upd - base), 32'd0);
    chk("post_rst_number", 32'(number_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
